// File: rtl/ni_mode_sequencer_pkg.sv
// Shared NI mode-sequencer definitions: mode index constants, index-width
// helper and per-mode dwell field extraction.
package ni_mode_sequencer_pkg;

  localparam int MAX_MODES   = 16;
  localparam int MAX_DWELL_W = 16;
  localparam int MAX_CFG_W   = MAX_MODES * MAX_DWELL_W;

  localparam logic [3:0] MODE_0  = 4'd0;
  localparam logic [3:0] MODE_1  = 4'd1;
  localparam logic [3:0] MODE_2  = 4'd2;
  localparam logic [3:0] MODE_3  = 4'd3;
  localparam logic [3:0] MODE_4  = 4'd4;
  localparam logic [3:0] MODE_5  = 4'd5;
  localparam logic [3:0] MODE_6  = 4'd6;
  localparam logic [3:0] MODE_7  = 4'd7;
  localparam logic [3:0] MODE_8  = 4'd8;
  localparam logic [3:0] MODE_9  = 4'd9;
  localparam logic [3:0] MODE_10 = 4'd10;
  localparam logic [3:0] MODE_11 = 4'd11;
  localparam logic [3:0] MODE_12 = 4'd12;
  localparam logic [3:0] MODE_13 = 4'd13;
  localparam logic [3:0] MODE_14 = 4'd14;
  localparam logic [3:0] MODE_15 = 4'd15;

  typedef logic [MAX_CFG_W-1:0]   dwell_cfg_t;
  typedef logic [MAX_DWELL_W-1:0] dwell_t;

  // Width of a mode index; a two-mode sequencer still needs one bit.
  function automatic int idx_width(input int num_modes);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < num_modes) w = i + 1;
    return w;
  endfunction

  // Field k of a packed dwell configuration with w-bit fields.
  function automatic dwell_t dwell_field(input dwell_cfg_t cfg, input int k, input int w);
    dwell_t mask;
    mask = dwell_t'((32'd1 << w) - 32'd1);
    return dwell_t'(cfg >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/ni_dwell_counter.sv
// Dwell counter for the NI mode sequencer: counts active ticks spent in the
// current mode and flags expiry once the count reaches the live limit.
module ni_dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               clear,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  function automatic logic [DWELL_W-1:0] sat_inc(input logic [DWELL_W-1:0] v);
    return (&v) ? v : v + DWELL_W'(1);
  endfunction

  // >= so that a limit lowered below the running count expires on the next tick
  assign expire = (count >= limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      if (clear || expire) count <= '0;
      else                 count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/ni_mode_sequencer.sv
// Round-robin NI mode sequencer: steps through NUM_MODES modes on the
// divided-clock tick with per-mode dwell, force-mode handshake and freeze.
module ni_mode_sequencer
  import ni_mode_sequencer_pkg::*;
#(
  parameter  int NUM_MODES = 2,
  parameter  int DWELL_W   = 4,
  localparam int IDX_W     = idx_width(NUM_MODES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sync_tick,
  input  logic                         enable,
  input  logic [NUM_MODES*DWELL_W-1:0] dwell_cfg,
  input  logic                         force_valid,
  input  logic [IDX_W-1:0]             force_mode,
  output logic                         force_ready,
  output logic [IDX_W-1:0]             mode_idx,
  output logic [NUM_MODES-1:0]         mode_onehot,
  output logic                         mode_lsb,
  output logic                         mode_chg,
  output logic                         err_bad_mode
);

  logic               active;
  logic               accept;
  logic               legal;
  logic               restart;
  logic               expire;
  logic [DWELL_W-1:0] limit;
  logic [IDX_W-1:0]   next_idx;
  dwell_cfg_t         cfg_ext;

  assign active      = sync_tick & enable;
  assign force_ready = active;
  assign accept      = force_valid & active;
  assign legal       = ({1'b0, force_mode} < (IDX_W+1)'(NUM_MODES));
  assign restart     = accept & legal;

  assign cfg_ext = dwell_cfg_t'(dwell_cfg);
  assign limit   = DWELL_W'(dwell_field(cfg_ext, int'(mode_idx), DWELL_W));

  ni_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .tick   (active),
    .clear  (restart),
    .limit  (limit),
    .expire (expire)
  );

  // An illegal force is consumed but leaves the natural advance untouched.
  always_comb begin
    next_idx = mode_idx;
    if (restart)
      next_idx = force_mode;
    else if (expire)
      next_idx = (mode_idx == IDX_W'(NUM_MODES-1)) ? '0 : mode_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_idx     <= IDX_W'(MODE_0);
      mode_onehot  <= NUM_MODES'(1);
      mode_chg     <= 1'b0;
      err_bad_mode <= 1'b0;
    end else begin
      mode_chg <= 1'b0;
      if (active) begin
        mode_idx    <= next_idx;
        mode_onehot <= NUM_MODES'(1) << next_idx;
        mode_chg    <= (next_idx != mode_idx);
        if (accept && !legal) err_bad_mode <= 1'b1;
      end
    end
  end

  assign mode_lsb = mode_idx[0];

endmodule

// File: tb/tb_ni_mode_sequencer.sv
// Self-checking bench for ni_mode_sequencer: directed scenarios plus random
// stimulus against a behavioural model, with a two-mode legacy instance.
module tb_ni_mode_sequencer;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sync_tick = 1'b0;
  logic          enable = 1'b0;
  logic          force_valid = 1'b0;
  logic [N*DW-1:0] dwell_cfg = '0;
  logic [IW-1:0] force_mode = '0;
  logic          force_ready;
  logic [IW-1:0] mode_idx;
  logic [N-1:0]  mode_onehot;
  logic          mode_lsb, mode_chg, err_bad_mode;

  logic          l_ready;
  logic [0:0]    l_idx;
  logic [1:0]    l_onehot;
  logic          l_lsb, l_chg_o, l_err;

  int n_chk = 0;
  int n_err = 0;
  int m_mode, m_cnt, m_err, m_chg;
  int l_mode, l_chg;

  always #5 clk = ~clk;

  ni_mode_sequencer #(.NUM_MODES(N), .DWELL_W(DW)) dut (
    .clk(clk), .reset(reset), .sync_tick(sync_tick), .enable(enable),
    .dwell_cfg(dwell_cfg), .force_valid(force_valid), .force_mode(force_mode),
    .force_ready(force_ready), .mode_idx(mode_idx), .mode_onehot(mode_onehot),
    .mode_lsb(mode_lsb), .mode_chg(mode_chg), .err_bad_mode(err_bad_mode)
  );

  ni_mode_sequencer #(.NUM_MODES(2), .DWELL_W(DW)) dut_legacy (
    .clk(clk), .reset(reset), .sync_tick(sync_tick), .enable(1'b1),
    .dwell_cfg(8'h00), .force_valid(1'b0), .force_mode(1'b0),
    .force_ready(l_ready), .mode_idx(l_idx), .mode_onehot(l_onehot),
    .mode_lsb(l_lsb), .mode_chg(l_chg_o), .err_bad_mode(l_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dw(input int m);
    return int'((dwell_cfg >> (DW * m)) & 12'hf);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_err = 0; m_chg = 0;
    l_mode = 0; l_chg = 0;
  endtask

  task automatic check_outputs();
    chk("mode_idx",    32'(mode_idx),     m_mode);
    chk("mode_onehot", 32'(mode_onehot),  1 << m_mode);
    chk("mode_lsb",    32'(mode_lsb),     m_mode & 1);
    chk("mode_chg",    32'(mode_chg),     m_chg);
    chk("err_bad",     32'(err_bad_mode), m_err);
    chk("leg_idx",     32'(l_idx),        l_mode);
    chk("leg_onehot",  32'(l_onehot),     1 << l_mode);
    chk("leg_lsb",     32'(l_lsb),        l_mode);
    chk("leg_chg",     32'(l_chg_o),      l_chg);
    chk("leg_err",     32'(l_err),        0);
  endtask

  // Apply one cycle of inputs just after a falling edge, predict, then check.
  task automatic step(input logic t, input logic e, input logic fv, input int fm);
    sync_tick = t; enable = e; force_valid = fv; force_mode = IW'(fm);
    #1;
    chk("force_ready", 32'(force_ready), 32'(t && e));
    chk("leg_ready",   32'(l_ready),     32'(t));
    m_chg = 0; l_chg = 0;
    if (t && e) begin
      if (fv && fm < N) begin
        m_chg  = (fm != m_mode) ? 1 : 0;
        m_mode = fm;
        m_cnt  = 0;
      end else begin
        if (fv) m_err = 1;
        if (m_cnt >= dw(m_mode)) begin
          m_mode = (m_mode + 1) % N;
          m_cnt  = 0;
          m_chg  = 1;
        end else begin
          m_cnt++;
        end
      end
    end
    if (t) begin
      l_mode = 1 - l_mode;
      l_chg  = 1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    sync_tick = 1'b0; force_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_idx",    32'(mode_idx),     0);
    chk("rst_onehot", 32'(mode_onehot),  1);
    chk("rst_err",    32'(err_bad_mode), 0);
    chk("rst_chg",    32'(mode_chg),     0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [6] = '{0, 0, 1, 2, 2, 0};
    logic t, e;
    logic pend;
    int   pfm;

    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // legacy toggle: tick every 8 clocks, all dwell zero
    for (int i = 0; i < 32; i++) step(i % 8 == 7, 1'b1, 1'b0, 0);
    chk("legacy_after4", 32'(l_lsb), 0);
    chk("main_after4",   32'(mode_idx), 1);

    // dwell D0=2, D1=0, D2=1 with wrap
    async_reset();
    dwell_cfg = 12'h102;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 0);
      chk("dwell_seq", 32'(mode_idx), seq[k]);
      step(1'b0, 1'b1, 1'b0, 0);
    end

    // force to mode 2 while in mode 0 with dwell count 1
    async_reset();
    step(1'b1, 1'b1, 1'b0, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 2);
    step(1'b1, 1'b1, 1'b1, 2);
    chk("force_idx", 32'(mode_idx), 2);
    chk("force_chg", 32'(mode_chg), 1);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("force_dwell", 32'(mode_idx), 2);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("force_wrap", 32'(mode_idx), 0);

    // illegal force index, then freeze across three ticks
    step(1'b1, 1'b1, 1'b1, 3);
    chk("bad_err", 32'(err_bad_mode), 1);
    step(1'b1, 1'b1, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1);
      step(1'b0, 1'b0, 1'b0, 0);
    end
    step(1'b1, 1'b1, 1'b0, 0);
    chk("resume_idx", 32'(mode_idx), 1);
    chk("err_sticky", 32'(err_bad_mode), 1);

    // reset while in mode 2
    step(1'b1, 1'b1, 1'b1, 2);
    chk("pre_rst_idx", 32'(mode_idx), 2);
    async_reset();

    // random phase
    pend = 1'b0; pfm = 0;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 7) != 0);
      if (!pend && $urandom_range(0, 5) == 0) begin
        pend = 1'b1;
        pfm  = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 49) == 0)
        dwell_cfg = 12'($urandom) & ($urandom_range(0, 1) != 0 ? 12'h333 : 12'hfff);
      step(t, e, pend, pfm);
      if (pend && t && e) pend = 1'b0;
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ni_mode_sequencer.md
Name: ni_mode_sequencer

Overview:
Parametrised successor of the NI two-state mode toggle. Steps the network interface through NUM_MODES operating modes in round-robin order, advancing only on the divided-clock synchronisation tick. Each mode dwells for a programmable number of ticks. Adds a valid/ready force-mode request, an enable/freeze control, a one-hot mode output and a mode-change strobe. Sits in the NI clock domain and drives the NI datapath mode selects.

Parameters:
NUM_MODES, 2, number of modes; legal range 2..16
DWELL_W, 4, width of each per-mode dwell field and of the dwell counter
IDX_W, derived, max(1, clog2(NUM_MODES)); not overridable

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-high reset
sync_tick  in  1  single-cycle divided-clock tick (clk_div_8 style); all mode advances align to it
enable  in  1  1 = sequencer runs; 0 = freeze state, ignore ticks and force requests
dwell_cfg  in  NUM_MODES*DWELL_W  field k = dwell value D_k for mode k; mode k lasts D_k+1 ticks
force_valid  in  1  force-mode request
force_mode  in  IDX_W  requested mode index
force_ready  out  1  request accepted this cycle (combinational)
mode_idx  out  IDX_W  current mode index
mode_onehot  out  NUM_MODES  one-hot of mode_idx
mode_lsb  out  1  mode_idx[0]; drop-in replacement for the legacy mode bit
mode_chg  out  1  one-cycle pulse, high in the first cycle a new mode_idx is visible
err_bad_mode  out  1  sticky flag: an accepted force request carried force_mode >= NUM_MODES

Behaviour:
- Reset (async assert, sync deassert use): mode_idx=0, mode_onehot=1, dwell_cnt=0, mode_chg=0, err_bad_mode=0. force_ready follows its equation.
- A cycle is active when sync_tick & enable.
- force_ready = sync_tick & enable. A handshake completes when force_valid & force_ready. Requests are held by the requester until ready.
- Active cycle with accepted force and legal force_mode:
  - mode_idx <= force_mode and dwell_cnt <= 0.
  - mode_chg pulses next cycle only if force_mode != mode_idx.
  - Force to the current mode only restarts dwell.
  - Force takes priority over the natural advance in the same tick.
- Active cycle with accepted force and illegal force_mode:
  - Request is consumed. err_bad_mode <= 1.
  - The natural advance/count for that tick proceeds as if no force was present.
- Active cycle without force:
  - If dwell_cnt >= D[mode_idx]: mode_idx <= (mode_idx == NUM_MODES-1) ? 0 : mode_idx+1, dwell_cnt <= 0, mode_chg pulses.
  - Otherwise dwell_cnt <= dwell_cnt+1.
  - The >= compare means that reducing dwell_cfg mid-dwell below dwell_cnt advances on the next tick.
- dwell_cfg is compared live and not latched. Software changes it only while enable=0, or accepts the rule above.
- Latency: mode_idx, mode_onehot, mode_lsb and mode_chg all update on the clock edge ending the active cycle, with 1-cycle latency from the tick. mode_chg is a registered pulse coincident with the new mode_idx.
- Inactive cycles: all state holds and mode_chg=0. sync_tick with enable=0 is dropped, not queued.
- dwell_cnt saturates at 2^DWELL_W-1. It cannot exceed D_max under the >= rule.
- Legacy equivalence: NUM_MODES=2 with all D=0 makes mode_lsb toggle on every tick, identical to the old block.
- Reset mid-dwell or mid-handshake returns to mode 0 immediately. The pending request is not accepted.
- err_bad_mode clears only on reset.

Decomposition:
- Shared NI package holds:
  - the mode index constants (MODE_0..)
  - the dwell field extraction function (slice k of dwell_cfg)
  - the IDX_W computation function
- One sub-module, ni_dwell_counter, is natural. It takes the tick/enable/clear inputs, the limit, and produces the expire output.
- The top level holds the mode register, force arbitration and output decode.

Test Plan:
- Legacy: NUM_MODES=2, dwell_cfg=0, enable=1, tick every 8 clks -> mode_lsb toggles 0,1,0,1 one clk after each tick; mode_chg pulses each time.
- Dwell and wrap: NUM_MODES=3, D={2,0,1} -> mode sequence per tick 0,0,0,1,2,2,0; mode_onehot 001,010,100 accordingly; wrap 2->0 pulses mode_chg.
- Force: during mode 0, dwell_cnt=1, force_valid with force_mode=2 held 5 clks before tick -> force_ready only in the tick cycle; mode_idx=2 next clk; dwell restarts at 0; mode_chg=1.
- Illegal force: NUM_MODES=3, force_mode=3 accepted -> err_bad_mode=1 and stays; mode advances naturally that tick.
- Freeze: enable=0 across 3 ticks -> mode_idx, dwell_cnt unchanged, force_ready=0, mode_chg=0; resume counts from the frozen dwell_cnt.
- Reset mid-operation: assert reset asynchronously while mode_idx=2 -> mode_idx=0, mode_onehot=001, err_bad_mode=0 without waiting for a clk edge.
